// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
package riscv_pkg;

  // Controller FSM states
  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBranch,
    StJal
  } state_e;

  // Instruction classes handed to the ALU decoder
  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } aluop_e;

  // Opcodes
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // ALUControl encodings
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;
  localparam logic [2:0] AluSrl = 3'b110;
  localparam logic [2:0] AluSll = 3'b111;

  // ALUSrcA encodings
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  // Immediate format selected purely from the opcode
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    unique case (op)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      OpJal:    return ImmJ;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps instruction class and function fields to ALUControl.
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_e      aluop,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        opb5,
  output logic [2:0]  alucontrol
);

  // Select ALU operation; sub only for R-type (op bit 5 set) with funct7b5
  always_comb begin
    alucontrol = AluAdd;
    unique case (aluop)
      AluOpAdd: alucontrol = AluAdd;
      AluOpSub: alucontrol = AluSub;
      AluOpFunct: begin
        unique case (funct3)
          3'b000:  alucontrol = (opb5 && funct7b5) ? AluSub : AluAdd;
          3'b001:  alucontrol = AluSll;
          3'b010:  alucontrol = AluSlt;
          3'b100:  alucontrol = AluXor;
          3'b101:  alucontrol = AluSrl;
          3'b110:  alucontrol = AluOr;
          3'b111:  alucontrol = AluAnd;
          default: alucontrol = AluAdd;
        endcase
      end
      default: alucontrol = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V controller: Moore FSM plus output decode.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Illegal
);

  state_e state_q, state_d;
  aluop_e aluop;

  // State register; reset drops any in-flight instruction back to fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecuteR;
          OpItype:         state_d = StExecuteI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Per-state output decode; everything not driven by a state stays zero
  always_comb begin
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBRs2;
    ResultSrc = ResAluOut;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    PCWrite   = 1'b0;
    Illegal   = 1'b0;
    aluop     = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        PCWrite   = 1'b1;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        unique case (op)
          OpLoad, OpStore, OpRtype, OpItype, OpBranch, OpJal: Illegal = 1'b0;
          default:                                            Illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
      end
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecuteR: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBRs2;
        aluop   = AluOpFunct;
      end
      StExecuteI: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        aluop   = AluOpFunct;
      end
      StAluWb: begin
        RegWrite = 1'b1;
      end
      StJal: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBFour;
        PCWrite = 1'b1;
      end
      StBranch: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBRs2;
        aluop   = AluOpSub;
        // beq/bne take the branch on Zero, inverted by funct3[0]
        if (funct3[2:1] == 2'b00) begin
          PCWrite = Zero ^ funct3[0];
        end
      end
      default: ;
    endcase
  end

  assign ImmSrc = imm_src(op);

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .opb5       (op[5]),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       PCWrite;
  logic       Illegal;

  int checks = 0;
  int passed = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .PCWrite    (PCWrite),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack fields in a fixed order: adr ir srcA srcB aluctl res imm mw rw pcw ill
  function automatic logic [16:0] pk(input logic adr, input logic ir, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] ac,
                                     input logic [1:0] rs, input logic [1:0] im,
                                     input logic mw, input logic rw, input logic pc,
                                     input logic il);
    return {adr, ir, sa, sb, ac, rs, im, mw, rw, pc, il};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc,
           MemWrite, RegWrite, PCWrite, Illegal};
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    op       = 7'b0000011;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    Zero     = 1'b0;
    #2;
    chk("reset_fetch", pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0, 0, 1, 0));
    step();
    chk("reset_held_edge", pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0, 0, 1, 0));
    @(negedge clk);
    reset = 1'b0;

    // lw: 5 cycles
    step(); chk("lw_decode",  pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    step(); chk("lw_memadr",  pk(0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    step(); chk("lw_memread", pk(1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    step(); chk("lw_memwb",   pk(0, 0, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 0, 1, 0, 0));
    step(); chk("lw_fetch",   pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0, 0, 1, 0));

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); chk("r_decode",   pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    step(); chk("r_sub_exec", pk(0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0));
    step(); chk("r_aluwb",    pk(0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0));
    step(); chk("r_fetch",    pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0, 0, 1, 0));

    // I-type addi with funct7b5 set stays add
    op = 7'b0010011;
    step(); chk("i_decode",   pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    step(); chk("i_add_exec", pk(0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    // srl/srai share one encoding; other funct3 values decoded within the same state
    funct3 = 3'b101; #1;
    chk("i_srl_exec", pk(0, 0, 2'b10, 2'b01, 3'b110, 2'b00, 2'b00, 0, 0, 0, 0));
    funct3 = 3'b001; #1;
    chk("i_sll_exec", pk(0, 0, 2'b10, 2'b01, 3'b111, 2'b00, 2'b00, 0, 0, 0, 0));
    funct3 = 3'b010; #1;
    chk("i_slt_exec", pk(0, 0, 2'b10, 2'b01, 3'b101, 2'b00, 2'b00, 0, 0, 0, 0));
    funct3 = 3'b100; #1;
    chk("i_xor_exec", pk(0, 0, 2'b10, 2'b01, 3'b100, 2'b00, 2'b00, 0, 0, 0, 0));
    funct3 = 3'b110; #1;
    chk("i_or_exec",  pk(0, 0, 2'b10, 2'b01, 3'b011, 2'b00, 2'b00, 0, 0, 0, 0));
    funct3 = 3'b111; #1;
    chk("i_and_exec", pk(0, 0, 2'b10, 2'b01, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0));
    step(); chk("i_aluwb",    pk(0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0));
    step(); chk("i_fetch",    pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0, 0, 1, 0));

    // beq, Zero=1 then Zero=0 within BRANCH; 3 cycles
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
    step(); chk("beq_decode", pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b10, 0, 0, 0, 0));
    step(); chk("beq_taken",  pk(0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b10, 0, 0, 1, 0));
    Zero = 1'b0; #1;
    chk("beq_not_taken", pk(0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b10, 0, 0, 0, 0));
    funct3 = 3'b001; #1;
    chk("bne_taken",     pk(0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b10, 0, 0, 1, 0));
    funct3 = 3'b100; Zero = 1'b1; #1;
    chk("blt_never",     pk(0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b10, 0, 0, 0, 0));
    step(); chk("br_fetch",   pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b10, 0, 0, 1, 0));

    // jal: 4 cycles
    op = 7'b1101111; Zero = 1'b0; #1;
    step(); chk("jal_decode", pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b11, 0, 0, 0, 0));
    step(); chk("jal_jal",    pk(0, 0, 2'b01, 2'b10, 3'b000, 2'b00, 2'b11, 0, 0, 1, 0));
    step(); chk("jal_aluwb",  pk(0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b11, 0, 1, 0, 0));
    step(); chk("jal_fetch",  pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b11, 0, 0, 1, 0));

    // illegal opcode: 2 cycles, Illegal only in DECODE
    op = 7'b0000000; funct3 = 3'b000;
    step(); chk("ill_decode", pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b00, 0, 0, 0, 1));
    step(); chk("ill_fetch",  pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0, 0, 1, 0));

    // sw: 4 cycles
    op = 7'b0100011; funct3 = 3'b010;
    step(); chk("sw_decode",  pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b01, 0, 0, 0, 0));
    step(); chk("sw_memadr",  pk(0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b01, 0, 0, 0, 0));
    step(); chk("sw_memwr",   pk(1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01, 1, 0, 0, 0));
    step(); chk("sw_fetch",   pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b01, 0, 0, 1, 0));

    // sw abandoned by an asynchronous reset pulse during MEMADR
    step(); chk("swr_decode", pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b01, 0, 0, 0, 0));
    step(); chk("swr_memadr", pk(0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b01, 0, 0, 0, 0));
    #2; reset = 1'b1; #1;
    chk("swr_async_fetch", pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b01, 0, 0, 1, 0));
    step(); chk("swr_rst_edge", pk(0, 1, 2'b00, 2'b10, 3'b000, 2'b10, 2'b01, 0, 0, 1, 0));
    @(negedge clk);
    reset = 1'b0;
    step(); chk("swr_decode2", pk(0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b01, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
